// File: rtl/pet_bus_pkg.sv
// Shared types for the PET external bus sequencer.
// Bus FSM states, cycle owner, and the captured CPU request.
package pet_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } bus_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_VID
  } bus_owner_t;

  typedef struct packed {
    logic [16:0] addr;
    logic        we;
    logic        ram_en;
    logic        readonly;
    logic        mirrored;
    logic        io_en;
  } cpu_req_t;

  localparam logic [7:0] UNMAPPED_READ = 8'hFF;

  function automatic logic [16:0] eff_addr(
    input logic [16:0] a,
    input logic        m,
    input logic [16:0] mask
  );
    return m ? (a & ~mask) : a;
  endfunction

endpackage

// File: rtl/bus_cycle_sequencer.sv
// Timed SRAM/IO bus cycles for CPU accesses, with video
// fetch reads slotted into idle bus time.
module bus_cycle_sequencer
  import pet_bus_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter logic [16:0] MIRROR_MASK   = 17'h00C00
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpu_req_i,
  input  logic [16:0] cpu_addr_i,
  input  logic        cpu_we_i,
  input  logic        ram_en_i,
  input  logic        is_readonly_i,
  input  logic        is_mirrored_i,
  input  logic        io_en_i,
  input  logic        vid_req_i,
  input  logic [16:0] vid_addr_i,
  input  logic [7:0]  ram_data_i,
  output logic [16:0] ram_addr_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o,
  output logic        io_strobe_n_o,
  output logic        cpu_done_o,
  output logic [7:0]  cpu_rdata_o,
  output logic        vid_ack_o,
  output logic [7:0]  vid_rdata_o
);

  localparam logic [2:0] LAST = 3'(STROBE_CYCLES - 1);

  bus_state_t  state_q, state_d;
  bus_owner_t  own_q, own_d;
  cpu_req_t    cur_q, cur_d;
  cpu_req_t    pend_req_q, pend_req_d;
  cpu_req_t    new_req;
  logic        pend_q, pend_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  vid_rdata_q, vid_rdata_d;
  logic        oe_q, we_q, io_q;
  logic        oe_d, we_d, io_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        mapped_d, wr_ok_d, in_strobe;
  logic        mapped_q;

  always_comb begin
    new_req          = '0;
    new_req.addr     = eff_addr(cpu_addr_i, is_mirrored_i,
                                MIRROR_MASK);
    new_req.we       = cpu_we_i;
    new_req.ram_en   = ram_en_i;
    new_req.readonly = is_readonly_i;
    new_req.mirrored = is_mirrored_i;
    new_req.io_en    = io_en_i;
  end

  assign mapped_q = cur_q.ram_en | cur_q.io_en;

  always_comb begin
    state_d     = state_q;
    own_d       = own_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_req_d  = pend_req_q;
    addr_d      = addr_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;

    if (cpu_req_i && !pend_q && state_q != IDLE) begin
      pend_d     = 1'b1;
      pend_req_d = new_req;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = SETUP;
          own_d   = OWN_CPU;
          cur_d   = pend_req_q;
          pend_d  = 1'b0;
        end else if (cpu_req_i) begin
          state_d = SETUP;
          own_d   = OWN_CPU;
          cur_d   = new_req;
        end else if (vid_req_i) begin
          // Video fetch looks like a plain mapped SRAM read.
          state_d      = SETUP;
          own_d        = OWN_VID;
          cur_d        = '0;
          cur_d.addr   = vid_addr_i;
          cur_d.ram_en = 1'b1;
        end
        if (state_d == SETUP) begin
          addr_d = cur_d.addr;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = '0;
      end
      STROBE: begin
        if (cnt_q == LAST) begin
          state_d = HOLD;
          if (own_q == OWN_VID) begin
            vid_rdata_d = ram_data_i;
          end else if (!cur_q.we) begin
            cpu_rdata_d = mapped_q ? ram_data_i
                                   : UNMAPPED_READ;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Writes to ROM or unmapped space run full length silently.
  always_comb begin
    in_strobe = (state_d == STROBE);
    mapped_d  = cur_d.ram_en | cur_d.io_en;
    wr_ok_d   = cur_d.we & ~cur_d.readonly & mapped_d;
    oe_d      = in_strobe & ~cur_d.we & mapped_d;
    we_d      = in_strobe & wr_ok_d;
    io_d      = in_strobe & cur_d.io_en
              & (~cur_d.we | wr_ok_d);
    done_d    = (state_d == HOLD) & (own_d == OWN_CPU);
    ack_d     = (state_d == HOLD) & (own_d == OWN_VID);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      own_q       <= OWN_CPU;
      cur_q       <= '0;
      pend_q      <= 1'b0;
      pend_req_q  <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      io_q        <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_req_q  <= pend_req_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      oe_q        <= oe_d;
      we_q        <= we_d;
      io_q        <= io_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
    end
  end

  assign ram_addr_o    = addr_q;
  assign ram_oe_n_o    = ~oe_q;
  assign ram_we_n_o    = ~we_q;
  assign io_strobe_n_o = ~io_q;
  assign cpu_done_o    = done_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign vid_ack_o     = ack_q;
  assign vid_rdata_o   = vid_rdata_q;

  a_single_pending: assert property (
    @(posedge clk_i) disable iff (!rst_n_i)
    !(cpu_req_i && pend_q)
  ) else $error("cpu_req_i while a request is already pending");

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Randomized bench for bus_cycle_sequencer against a
// cycle-timeline reference model.
module tb_bus_cycle_sequencer;

  localparam int S = 2;
  localparam logic [16:0] MASK = 17'h00C00;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [16:0] cpu_addr;
  logic        cpu_we;
  logic        ram_en;
  logic        ro;
  logic        mir;
  logic        io_en;
  logic        vid_req;
  logic [16:0] vid_addr;
  logic [7:0]  ram_data;
  logic [16:0] ram_addr;
  logic        oe_n;
  logic        we_n;
  logic        io_n;
  logic        done;
  logic [7:0]  cpu_rdata;
  logic        ack;
  logic [7:0]  vid_rdata;

  int tests;
  int fails;
  logic [7:0] exp_cpu_rd;

  bus_cycle_sequencer #(
    .STROBE_CYCLES(S),
    .MIRROR_MASK  (MASK)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .cpu_req_i    (cpu_req),
    .cpu_addr_i   (cpu_addr),
    .cpu_we_i     (cpu_we),
    .ram_en_i     (ram_en),
    .is_readonly_i(ro),
    .is_mirrored_i(mir),
    .io_en_i      (io_en),
    .vid_req_i    (vid_req),
    .vid_addr_i   (vid_addr),
    .ram_data_i   (ram_data),
    .ram_addr_o   (ram_addr),
    .ram_oe_n_o   (oe_n),
    .ram_we_n_o   (we_n),
    .io_strobe_n_o(io_n),
    .cpu_done_o   (done),
    .cpu_rdata_o  (cpu_rdata),
    .vid_ack_o    (ack),
    .vid_rdata_o  (vid_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    cpu_we   = 1'b0;
    ram_en   = 1'b0;
    ro       = 1'b0;
    mir      = 1'b0;
    io_en    = 1'b0;
    vid_req  = 1'b0;
    vid_addr = '0;
    ram_data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (ram_addr !== 17'h0) begin
      fails++;
      $display("FAIL reset_addr got %h want 0", ram_addr);
    end
    tests++;
    if ({oe_n, we_n, io_n} !== 3'b111) begin
      fails++;
      $display("FAIL reset_strobes got %b want 111",
               {oe_n, we_n, io_n});
    end
    tests++;
    if ({done, ack} !== 2'b00) begin
      fails++;
      $display("FAIL reset_pulses got %b want 00",
               {done, ack});
    end
    tests++;
    if ({cpu_rdata, vid_rdata} !== 16'h0) begin
      fails++;
      $display("FAIL reset_rdata got %h want 0",
               {cpu_rdata, vid_rdata});
    end
    exp_cpu_rd = 8'h00;
    rst_n = 1'b1;
    tick();
  endtask

  // One isolated CPU cycle from IDLE; dat[8]=1 means random data.
  task automatic run_cpu(
    input logic [16:0] a,
    input logic        w,
    input logic        re,
    input logic        r_o,
    input logic        m,
    input logic        io,
    input logic [8:0]  dat
  );
    logic [16:0] ea;
    logic [2:0]  es;
    logic [7:0]  samp;
    bit          mapped;
    ea = m ? (a & 17'h1F3FF) : a;
    mapped = re || io;
    es = 3'b000;
    if (!w) begin
      if (mapped) es[2] = 1'b1;
      if (io) es[0] = 1'b1;
    end else if (!r_o && mapped) begin
      es[1] = 1'b1;
      if (io) es[0] = 1'b1;
    end
    samp = 8'h00;
    cpu_req  = 1'b1;
    cpu_addr = a;
    cpu_we   = w;
    ram_en   = re;
    ro       = r_o;
    mir      = m;
    io_en    = io;
    ram_data = dat[8] ? 8'($urandom) : dat[7:0];
    tick();
    cpu_req  = 1'b0;
    cpu_addr = 17'($urandom);
    for (int t = 1; t <= 3 + S; t++) begin
      logic [2:0] want;
      want = (t >= 2 && t <= 1 + S) ? ~es : 3'b111;
      tests++;
      if ({oe_n, we_n, io_n} !== want) begin
        fails++;
        $display("FAIL cpu_strobes a=%h t=%0d got %b want %b",
                 a, t, {oe_n, we_n, io_n}, want);
      end
      if (t <= 2 + S) begin
        tests++;
        if (ram_addr !== ea) begin
          fails++;
          $display("FAIL cpu_addr a=%h t=%0d got %h want %h",
                   a, t, ram_addr, ea);
        end
      end
      tests++;
      if (done !== (t == 2 + S) || ack !== 1'b0) begin
        fails++;
        $display("FAIL cpu_done a=%h t=%0d got %b%b want %b0",
                 a, t, done, ack, (t == 2 + S));
      end
      if (t == 2 + S) begin
        if (!w) exp_cpu_rd = mapped ? samp : 8'hFF;
        tests++;
        if (cpu_rdata !== exp_cpu_rd) begin
          fails++;
          $display("FAIL cpu_rdata a=%h got %h want %h",
                   a, cpu_rdata, exp_cpu_rd);
        end
      end
      ram_data = dat[8] ? 8'($urandom) : dat[7:0];
      if (t == 1 + S) samp = ram_data;
      tick();
    end
  endtask

  task automatic test_spec_vectors();
    run_cpu(17'h01234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
            9'h05A);
    run_cpu(17'h0F000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
            9'h100);
    run_cpu(17'h08C10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
            9'h100);
    run_cpu(17'h0E810, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
            9'h100);
    run_cpu(17'h0E811, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
            9'h100);
    run_cpu(17'h0C000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            9'h033);
    run_cpu(17'h0C001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
            9'h100);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [4:0] f;
      f = 5'($urandom);
      run_cpu(17'($urandom), f[0], f[1], f[2], f[3], f[4],
              9'h100);
    end
  endtask

  // mode 0: CPU+VID together; 1: CPU in VID STROBE;
  // 2: CPU in VID HOLD.
  task automatic test_race(input int mode);
    logic [7:0]  dat [0:39];
    logic [16:0] alog [0:39];
    logic [16:0] ca;
    logic [16:0] va;
    int cpu_t, done_t, ack_t, nd, na;
    int want_done, want_ack;
    ca = 17'($urandom);
    va = 17'($urandom);
    cpu_t = (mode == 0) ? 0 : (mode == 1) ? 2 : 2 + S;
    done_t = -1;
    ack_t  = -1;
    nd = 0;
    na = 0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) begin
        alog[t] = ram_addr;
        if (done) begin
          nd++;
          if (done_t < 0) done_t = t;
        end
        if (ack) begin
          na++;
          if (ack_t < 0) ack_t = t;
          vid_req = 1'b0;
        end
      end
      if (t == 0) begin
        vid_req  = 1'b1;
        vid_addr = va;
      end
      cpu_req = (t == cpu_t);
      if (t == cpu_t) begin
        cpu_addr = ca;
        cpu_we   = 1'b0;
        ram_en   = 1'b1;
        ro       = 1'b0;
        mir      = 1'b0;
        io_en    = 1'b0;
      end
      ram_data = 8'($urandom);
      dat[t] = ram_data;
      tick();
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
    want_done = (mode == 0) ? 2 + S : 5 + 2 * S;
    want_ack  = (mode == 0) ? 5 + 2 * S : 2 + S;
    tests++;
    if (nd != 1 || na != 1) begin
      fails++;
      $display("FAIL race%0d_counts got %0d/%0d want 1/1",
               mode, nd, na);
    end
    tests++;
    if (done_t != want_done || ack_t != want_ack) begin
      fails++;
      $display("FAIL race%0d_timing got %0d/%0d want %0d/%0d",
               mode, done_t, ack_t, want_done, want_ack);
    end
    if (done_t == want_done && ack_t == want_ack) begin
      exp_cpu_rd = dat[done_t - 1];
      tests++;
      if (cpu_rdata !== exp_cpu_rd) begin
        fails++;
        $display("FAIL race%0d_cpu_rdata got %h want %h",
                 mode, cpu_rdata, exp_cpu_rd);
      end
      tests++;
      if (vid_rdata !== dat[ack_t - 1]) begin
        fails++;
        $display("FAIL race%0d_vid_rdata got %h want %h",
                 mode, vid_rdata, dat[ack_t - 1]);
      end
      tests++;
      if (alog[done_t - 1 - S] !== ca ||
          alog[ack_t - 1 - S] !== va) begin
        fails++;
        $display("FAIL race%0d_addr got %h/%h want %h/%h",
                 mode, alog[done_t - 1 - S],
                 alog[ack_t - 1 - S], ca, va);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    cpu_req  = 1'b1;
    cpu_addr = 17'h01111;
    cpu_we   = 1'b0;
    ram_en   = 1'b1;
    ro       = 1'b0;
    mir      = 1'b0;
    io_en    = 1'b1;
    tick();
    cpu_req = 1'b0;
    tick();
    tests++;
    if ({oe_n, io_n} !== 2'b00) begin
      fails++;
      $display("FAIL rstmid_pre got %b want 00", {oe_n, io_n});
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({oe_n, we_n, io_n} !== 3'b111 || ram_addr !== 17'h0) begin
      fails++;
      $display("FAIL rstmid_async got %b %h want 111 0",
               {oe_n, we_n, io_n}, ram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cpu_rd = 8'h00;
    bad = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done || ack || {oe_n, we_n, io_n} != 3'b111) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rstmid_quiet got %0d active cycles want 0",
               bad);
    end
    tests++;
    if (cpu_rdata !== exp_cpu_rd) begin
      fails++;
      $display("FAIL rstmid_rdata got %h want 00", cpu_rdata);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_spec_vectors();
    test_random();
    for (int r = 0; r < 2; r++) begin
      test_race(0);
      test_race(1);
      test_race(2);
    end
    test_reset_mid();
    test_spec_vectors();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
